// File: rtl/lru_cache_wb_pkg.sv
// Shared definitions for the write-back LRU cache: FSM state encoding and
// a ceiling-log2 helper used to size way indices and age fields.
package lru_cache_wb_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_EVICT  = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;
  localparam logic [2:0] ST_FLUSH  = 3'd5;

  // Smallest r such that 2**r >= value (returns at least 1 for value <= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/lru_cache_wb_if.sv
// CPU-side and backing-memory-side signals of the cache, bundled so the
// cache (slave) and its user / memory model (master) connect in one port.
interface lru_cache_wb_if #(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 req;
  logic                 rw;
  logic [A_WIDTH-1:0]   addr;
  logic [D_WIDTH-1:0]   wdata;
  logic                 flush;
  logic                 ready;
  logic                 done;
  logic                 hit;
  logic [D_WIDTH-1:0]   rdata;
  logic                 mem_req;
  logic                 mem_rw;
  logic [A_WIDTH-1:0]   mem_addr;
  logic [D_WIDTH-1:0]   mem_wdata;
  logic [D_WIDTH-1:0]   mem_rdata;
  logic                 mem_ack;
  logic [CNT_WIDTH-1:0] hit_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt;

  modport master (
    output req, rw, addr, wdata, flush, mem_rdata, mem_ack,
    input  ready, done, hit, rdata, mem_req, mem_rw, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );

  modport slave (
    input  req, rw, addr, wdata, flush, mem_rdata, mem_ack,
    output ready, done, hit, rdata, mem_req, mem_rw, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/lru_cache_wb_lru_age.sv
// Per-way age tracking for true LRU: age 0 is most recently used, the way
// holding age N_WAYS-1 is the replacement candidate. Ages always form a
// permutation, so exactly one way matches the oldest value.
module lru_age
  import lru_cache_wb_pkg::*;
#(
  parameter int N_WAYS = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       access,
  input  logic [clog2(N_WAYS)-1:0]   access_way,
  output logic [clog2(N_WAYS)-1:0]   lru_way
);

  localparam int IDX_W = clog2(N_WAYS);
  localparam logic [IDX_W-1:0] OLDEST = IDX_W'(N_WAYS - 1);

  logic [IDX_W-1:0] age_q [N_WAYS];
  logic [IDX_W-1:0] age_d [N_WAYS];
  logic [IDX_W-1:0] old_age;

  // Touched way becomes MRU; every way younger than it ages by one.
  always_comb begin
    age_d   = age_q;
    old_age = age_q[access_way];
    if (access) begin
      for (int i = 0; i < N_WAYS; i++) begin
        if (IDX_W'(i) == access_way) begin
          age_d[i] = '0;
        end else if (age_q[i] < old_age) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // Pick out the way currently holding the oldest age.
  always_comb begin
    lru_way = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (age_q[i] == OLDEST) lru_way = IDX_W'(i);
    end
  end

  // Age registers; reset gives way i the age i.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < N_WAYS; i++) age_q[i] <= IDX_W'(i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/lru_cache_wb.sv
// Fully associative write-back, write-allocate cache with true LRU
// replacement, a flush command and saturating hit/miss statistics.
module lru_cache_wb
  import lru_cache_wb_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 8,
  parameter int N_WAYS    = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic           clk,
  input logic           clr,
  lru_cache_wb_if.slave bus
);

  localparam int IDX_W = clog2(N_WAYS);

  logic [2:0]           state_q, state_d;
  logic [N_WAYS-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [A_WIDTH-1:0]   tag_q [N_WAYS];
  logic [A_WIDTH-1:0]   tag_d [N_WAYS];
  logic [D_WIDTH-1:0]   data_q [N_WAYS];
  logic [D_WIDTH-1:0]   data_d [N_WAYS];
  logic                 rw_q, rw_d, hit_q, hit_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [D_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [IDX_W-1:0]     victim_q, victim_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic                 is_hit, has_invalid, has_dirty;
  logic [IDX_W-1:0]     hit_way, free_way, dirty_way, lru_way, victim_way;
  logic                 age_access;
  logic [IDX_W-1:0]     age_way;
  logic                 install_en, install_dirty;
  logic [IDX_W-1:0]     install_way;
  logic [D_WIDTH-1:0]   install_data;

  lru_age #(.N_WAYS(N_WAYS)) u_lru_age (
    .clk        (clk),
    .clr        (clr),
    .access     (age_access),
    .access_way (age_way),
    .lru_way    (lru_way)
  );

  // Parallel tag match plus lowest-index invalid and lowest-index dirty way.
  always_comb begin
    is_hit      = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    free_way    = '0;
    has_dirty   = 1'b0;
    dirty_way   = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == addr_q)) begin
        is_hit  = 1'b1;
        hit_way = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        has_invalid = 1'b1;
        free_way    = IDX_W'(i);
      end
      if (valid_q[i] && dirty_q[i]) begin
        has_dirty = 1'b1;
        dirty_way = IDX_W'(i);
      end
    end
    victim_way = has_invalid ? free_way : lru_way;
  end

  // Controller: request latch, lookup, eviction, fill, response and flush.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    data_d        = data_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    victim_d      = victim_q;
    hit_d         = hit_q;
    rdata_d       = rdata_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    age_access    = 1'b0;
    age_way       = '0;
    install_en    = 1'b0;
    install_dirty = 1'b0;
    install_way   = '0;
    install_data  = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          rw_d    = bus.rw;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          state_d = ST_LOOKUP;
        end else if (bus.flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_LOOKUP: begin
        if (is_hit) begin
          hit_d      = 1'b1;
          age_access = 1'b1;
          age_way    = hit_way;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          if (rw_q) begin
            data_d[hit_way]  = wdata_q;
            dirty_d[hit_way] = 1'b1;
          end else begin
            rdata_d = data_q[hit_way];
          end
          state_d = ST_RESP;
        end else begin
          hit_d    = 1'b0;
          victim_d = victim_way;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
          if (valid_q[victim_way] && dirty_q[victim_way]) begin
            state_d = ST_EVICT;
          end else if (rw_q) begin
            install_en    = 1'b1;
            install_way   = victim_way;
            install_data  = wdata_q;
            install_dirty = 1'b1;
            state_d       = ST_RESP;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_EVICT: begin
        if (bus.mem_ack) begin
          if (rw_q) begin
            install_en    = 1'b1;
            install_way   = victim_q;
            install_data  = wdata_q;
            install_dirty = 1'b1;
            state_d       = ST_RESP;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (bus.mem_ack) begin
          install_en   = 1'b1;
          install_way  = victim_q;
          install_data = bus.mem_rdata;
          rdata_d      = bus.mem_rdata;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (!has_dirty) begin
          hit_d   = 1'b0;
          state_d = ST_RESP;
        end else if (bus.mem_ack) begin
          dirty_d[dirty_way] = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (install_en) begin
      valid_d[install_way] = 1'b1;
      dirty_d[install_way] = install_dirty;
      tag_d[install_way]   = addr_q;
      data_d[install_way]  = install_data;
      age_access           = 1'b1;
      age_way              = install_way;
    end
  end

  // Memory port is driven purely from registered state, so it stays stable
  // while waiting for mem_ack and drops as soon as reset forces IDLE.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      ST_EVICT: begin
        bus.mem_req   = 1'b1;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = tag_q[victim_q];
        bus.mem_wdata = data_q[victim_q];
      end
      ST_FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
      end
      ST_FLUSH: begin
        if (has_dirty) begin
          bus.mem_req   = 1'b1;
          bus.mem_rw    = 1'b1;
          bus.mem_addr  = tag_q[dirty_way];
          bus.mem_wdata = data_q[dirty_way];
        end
      end
      default: begin
        bus.mem_req = 1'b0;
      end
    endcase
  end

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.done     = (state_q == ST_RESP);
  assign bus.hit      = hit_q;
  assign bus.rdata    = rdata_q;
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;

  // State, way storage, latched request and statistics registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < N_WAYS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      victim_q   <= '0;
      hit_q      <= 1'b0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      victim_q   <= victim_d;
      hit_q      <= hit_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_lru_cache_wb.sv
// Directed self-checking bench for lru_cache_wb: miss fill, hit latency,
// dirty eviction, LRU victim choice, flush ordering and mid-fill reset.
module tb_lru_cache_wb;

  logic clk = 1'b0;
  logic clr;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  lru_cache_wb_if #(.D_WIDTH(8), .A_WIDTH(8), .CNT_WIDTH(16)) bus ();

  lru_cache_wb #(.D_WIDTH(8), .A_WIDTH(8), .N_WAYS(4), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         mem_latency  = 2;
  logic       mem_hold     = 1'b0;
  logic [7:0] fill_data    = 8'h00;
  logic       log_rw   [$];
  logic [7:0] log_addr [$];
  logic [7:0] log_data [$];

  int         cyc;
  logic       got_done, got_hit;
  logic [7:0] got_rdata;
  logic       done_seen;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Backing-memory model: acks after mem_latency cycles of mem_req and logs
  // the request seen at the moment of the ack.
  initial begin : mem_model
    int wait_cnt;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end else if (clr && bus.mem_req && !mem_hold) begin
        wait_cnt++;
        if (wait_cnt >= mem_latency) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = fill_data;
          log_rw.push_back(bus.mem_rw);
          log_addr.push_back(bus.mem_addr);
          log_data.push_back(bus.mem_wdata);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Issue one request (or flush) from IDLE and wait, bounded, for done.
  task automatic applyStimulus(input string tag, input logic is_flush,
                               input logic is_write, input logic [7:0] a,
                               input logic [7:0] d);
    bus.req   = !is_flush;
    bus.flush = is_flush;
    bus.rw    = is_write;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req   = 1'b0;
    bus.flush = 1'b0;
    cyc       = 0;
    got_done  = 1'b0;
    got_hit   = 1'b0;
    got_rdata = 8'h00;
    while (!bus.done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (bus.done) begin
      got_done  = 1'b1;
      got_hit   = bus.hit;
      got_rdata = bus.rdata;
    end
    checkOutput({tag, "_done"}, 32'(got_done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    log_rw.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic checkLog(input string tag, input int idx, input logic rw,
                          input logic [7:0] a, input logic [7:0] d);
    if (log_addr.size() > idx) begin
      checkOutput({tag, "_rw"}, 32'(log_rw[idx]), 32'(rw));
      checkOutput({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
      if (rw) checkOutput({tag, "_wdata"}, 32'(log_data[idx]), 32'(d));
    end else begin
      checkOutput({tag, "_present"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  // Global time limit so a stuck design still ends the run.
  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    clr       = 1'b0;
    bus.req   = 1'b0;
    bus.flush = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = 8'h00;
    bus.wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset values while clr is held low.
    checkOutput("rst_ready", 32'(bus.ready), 32'd1);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_hit", 32'(bus.hit), 32'd0);
    checkOutput("rst_rdata", 32'(bus.rdata), 32'd0);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    checkOutput("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    clr = 1'b1;

    // Read miss on 0x10 filled with 0xA5 after 3 cycles.
    mem_latency = 3;
    fill_data   = 8'hA5;
    applyStimulus("rd_miss", 1'b0, 1'b0, 8'h10, 8'h00);
    checkOutput("rd_miss_hit", 32'(got_hit), 32'd0);
    checkOutput("rd_miss_rdata", 32'(got_rdata), 32'hA5);
    checkOutput("rd_miss_miss_cnt", 32'(bus.miss_cnt), 32'd1);
    checkOutput("rd_miss_log_size", 32'(log_addr.size()), 32'd1);
    checkLog("rd_miss_fill", 0, 1'b0, 8'h10, 8'h00);

    // Read hit on 0x10: done seen one edge after accept (second edge samples it).
    applyStimulus("rd_hit", 1'b0, 1'b0, 8'h10, 8'h00);
    checkOutput("rd_hit_latency", 32'(cyc), 32'd1);
    checkOutput("rd_hit_hit", 32'(got_hit), 32'd1);
    checkOutput("rd_hit_rdata", 32'(got_rdata), 32'hA5);
    checkOutput("rd_hit_hit_cnt", 32'(bus.hit_cnt), 32'd1);
    checkOutput("rd_hit_no_mem", 32'(log_addr.size()), 32'd1);

    // Fill all four ways dirty, then a fifth write evicts LRU 0x01/0x11.
    doReset();
    mem_latency = 2;
    for (int i = 1; i <= 4; i++)
      applyStimulus("wr_fill", 1'b0, 1'b1, 8'(i), 8'(i * 8'h11));
    checkOutput("wr_fill_no_mem", 32'(log_addr.size()), 32'd0);
    applyStimulus("wr_evict", 1'b0, 1'b1, 8'h05, 8'h55);
    checkOutput("wr_evict_hit", 32'(got_hit), 32'd0);
    checkOutput("wr_evict_log_size", 32'(log_addr.size()), 32'd1);
    checkLog("wr_evict_wb", 0, 1'b1, 8'h01, 8'h11);
    checkOutput("wr_evict_miss_cnt", 32'(bus.miss_cnt), 32'd5);
    applyStimulus("rd_installed", 1'b0, 1'b0, 8'h05, 8'h00);
    checkOutput("rd_installed_hit", 32'(got_hit), 32'd1);
    checkOutput("rd_installed_rdata", 32'(got_rdata), 32'h55);

    // Touching 0x01 makes 0x02 the LRU victim.
    doReset();
    for (int i = 1; i <= 4; i++)
      applyStimulus("lru_fill", 1'b0, 1'b1, 8'(i), 8'(i * 8'h11));
    applyStimulus("lru_touch", 1'b0, 1'b0, 8'h01, 8'h00);
    checkOutput("lru_touch_rdata", 32'(got_rdata), 32'h11);
    applyStimulus("lru_evict", 1'b0, 1'b1, 8'h05, 8'h55);
    checkOutput("lru_evict_log_size", 32'(log_addr.size()), 32'd1);
    checkLog("lru_evict_wb", 0, 1'b1, 8'h02, 8'h22);

    // Dirty ways 0 and 2 (way 1 clean from a fill), then flush twice.
    doReset();
    fill_data = 8'h77;
    applyStimulus("fl_w0", 1'b0, 1'b1, 8'h01, 8'h11);
    applyStimulus("fl_r1", 1'b0, 1'b0, 8'h02, 8'h00);
    checkOutput("fl_r1_rdata", 32'(got_rdata), 32'h77);
    applyStimulus("fl_w2", 1'b0, 1'b1, 8'h03, 8'h33);
    log_rw.delete();
    log_addr.delete();
    log_data.delete();
    applyStimulus("flush1", 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("flush1_hit", 32'(got_hit), 32'd0);
    checkOutput("flush1_log_size", 32'(log_addr.size()), 32'd2);
    checkLog("flush1_wb0", 0, 1'b1, 8'h01, 8'h11);
    checkLog("flush1_wb1", 1, 1'b1, 8'h03, 8'h33);
    applyStimulus("flush2", 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("flush2_latency", 32'(cyc), 32'd1);
    checkOutput("flush2_log_size", 32'(log_addr.size()), 32'd2);
    checkOutput("flush_miss_cnt", 32'(bus.miss_cnt), 32'd3);
    checkOutput("flush_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    applyStimulus("post_flush_rd", 1'b0, 1'b0, 8'h01, 8'h00);
    checkOutput("post_flush_hit", 32'(got_hit), 32'd1);
    checkOutput("post_flush_rdata", 32'(got_rdata), 32'h11);

    // Reset while a fill is outstanding.
    mem_hold  = 1'b1;
    bus.req   = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 8'h40;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_fill_mem_req", 32'(bus.mem_req), 32'd1);
    checkOutput("mid_fill_mem_addr", 32'(bus.mem_addr), 32'h40);
    clr = 1'b0;
    #1;
    checkOutput("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.ready), 32'd1);
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen = 1'b1;
    end
    checkOutput("mid_rst_no_done", 32'(done_seen), 32'd0);
    checkOutput("mid_rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    clr      = 1'b1;
    mem_hold = 1'b0;
    log_rw.delete();
    log_addr.delete();
    log_data.delete();
    fill_data = 8'h99;
    applyStimulus("after_rst_rd", 1'b0, 1'b0, 8'h01, 8'h00);
    checkOutput("after_rst_hit", 32'(got_hit), 32'd0);
    checkOutput("after_rst_rdata", 32'(got_rdata), 32'h99);
    checkOutput("after_rst_miss_cnt", 32'(bus.miss_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
